// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one tinyalu between N_REQ requesters.
// Round-robin grant, operands latched and held on the ALU port, alu_start
// held until alu_done, then a one-cycle tagged response to the winner.
// Opcode 000 is a no-op: answered with result 0 without touching the ALU.
// Optional feature macro: ALU_TIMEOUT_EN adds a BUSY watchdog that aborts
// after TIMEOUT_CYC cycles with rsp_err=1; without it rsp_err is tied low.
module alu_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_a,
    input  logic [N_REQ*DATA_W-1:0]    req_b,
    input  logic [N_REQ*3-1:0]         req_op,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [2*DATA_W-1:0]        rsp_result,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [2:0]                 alu_op,
    output logic                       alu_start,
    output logic                       alu_reset_n,
    input  logic                       alu_done,
    input  logic [2*DATA_W-1:0]        alu_result
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  start_q, start_d;
    logic [2*DATA_W-1:0]   result_q, result_d;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    // Arbitration result for the current cycle
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [DATA_W-1:0]     win_a;
    logic [DATA_W-1:0]     win_b;
    logic [2:0]            win_op;

    // Round-robin search: first valid requester starting just after the last winner
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
        win_a  = req_a[int'(win_id)*DATA_W +: DATA_W];
        win_b  = req_b[int'(win_id)*DATA_W +: DATA_W];
        win_op = req_op[int'(win_id)*3 +: 3];
    end

    // Next-state and grant logic for the IDLE/BUSY/RESP sequencer
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        start_d   = start_q;
        result_d  = result_q;
        req_ready = '0;
`ifdef ALU_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    ptr_d             = win_id;
                    id_d              = win_id;
                    a_d               = win_a;
                    b_d               = win_b;
                    op_d              = win_op;
`ifdef ALU_TIMEOUT_EN
                    err_d             = 1'b0;
                    cnt_d             = '0;
`endif
                    if (win_op != 3'b000) begin
                        start_d = 1'b1;
                        state_d = S_BUSY;
                    end else begin
                        // No-op never raises alu_done, so answer directly
                        result_d = '0;
                        state_d  = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                if (alu_done) begin
                    result_d = alu_result;
                    start_d  = 1'b0;
                    state_d  = S_RESP;
                end
`ifdef ALU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    start_d  = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= ID_W'(N_REQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
`ifdef ALU_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            start_q  <= start_d;
            result_q <= result_d;
`ifdef ALU_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign alu_start   = start_q;
    assign alu_reset_n = ~reset;

`ifdef ALU_TIMEOUT_EN
    assign rsp_err = err_q & (state_q == S_RESP);
`else
    assign rsp_err = 1'b0;
`endif

endmodule
